// File: rtl/id_ex_stage_pkg.sv
// Shared types for the decode/execute boundary: result-source encodings,
// ALU op codes and the packed control bundle carried from D into E.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    result_src_e result_src;
    logic        branch;
    logic        jump;
    logic [3:0]  alu_control;
    logic        addr_mode;
    logic [2:0]  funct3;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational load-use detector for the D/E boundary. A hold from later
// stages or a flush from E overrides the load-use bubble.
module hazard_unit
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  rst,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic                  e_valid,
  input  logic                  e_reg_write,
  input  logic [1:0]            e_result_src,
  input  logic [REG_ADDR_W-1:0] e_rd,
  input  logic                  flush_in,
  input  logic                  stall_in,
  output logic                  hazard,
  output logic                  stall_f,
  output logic                  stall_d
);

  logic load_use;

  always_comb begin
    load_use = d_valid && e_valid && e_reg_write &&
               (e_result_src == RES_MEM) && (e_rd != '0) &&
               ((e_rd == d_rs1) || (e_rd == d_rs2));
    hazard   = load_use && !flush_in && !stall_in && !rst;
    stall_f  = !rst && (stall_in || hazard);
    stall_d  = stall_f;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  input  logic                  d_reg_write,
  input  logic                  d_mem_write,
  input  logic                  d_alu_src,
  input  logic                  d_branch,
  input  logic                  d_jump,
  input  logic                  d_addr_mode,
  input  logic [1:0]            d_result_src,
  input  logic [3:0]            d_alu_control,
  input  logic [2:0]            d_funct3,
  input  logic [DATA_WIDTH-1:0] d_rd1,
  input  logic [DATA_WIDTH-1:0] d_rd2,
  input  logic [DATA_WIDTH-1:0] d_imm,
  input  logic [DATA_WIDTH-1:0] d_pc,
  input  logic [DATA_WIDTH-1:0] d_pc_plus4,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic                  flush_in,
  input  logic                  stall_in,
  output logic                  e_valid,
  output logic                  e_reg_write,
  output logic                  e_mem_write,
  output logic                  e_alu_src,
  output logic                  e_branch,
  output logic                  e_jump,
  output logic                  e_addr_mode,
  output logic [1:0]            e_result_src,
  output logic [3:0]            e_alu_control,
  output logic [2:0]            e_funct3,
  output logic [DATA_WIDTH-1:0] e_rd1,
  output logic [DATA_WIDTH-1:0] e_rd2,
  output logic [DATA_WIDTH-1:0] e_imm,
  output logic [DATA_WIDTH-1:0] e_pc,
  output logic [DATA_WIDTH-1:0] e_pc_plus4,
  output logic [REG_ADDR_W-1:0] e_rs1,
  output logic [REG_ADDR_W-1:0] e_rs2,
  output logic [REG_ADDR_W-1:0] e_rd,
  output logic                  stall_f,
  output logic                  stall_d
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  ctrl_t d_ctrl;
  ctrl_t e_ctrl;
  logic  hazard;

  assign d_ctrl = '{
    reg_write:   d_reg_write,
    mem_write:   d_mem_write,
    alu_src:     d_alu_src,
    result_src:  result_src_e'(d_result_src),
    branch:      d_branch,
    jump:        d_jump,
    alu_control: d_alu_control,
    addr_mode:   d_addr_mode,
    funct3:      d_funct3
  };

  assign e_reg_write   = e_ctrl.reg_write;
  assign e_mem_write   = e_ctrl.mem_write;
  assign e_alu_src     = e_ctrl.alu_src;
  assign e_result_src  = e_ctrl.result_src;
  assign e_branch      = e_ctrl.branch;
  assign e_jump        = e_ctrl.jump;
  assign e_alu_control = e_ctrl.alu_control;
  assign e_addr_mode   = e_ctrl.addr_mode;
  assign e_funct3      = e_ctrl.funct3;

  hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .rst          (rst),
    .d_valid      (d_valid),
    .d_rs1        (d_rs1),
    .d_rs2        (d_rs2),
    .e_valid      (e_valid),
    .e_reg_write  (e_reg_write),
    .e_result_src (e_result_src),
    .e_rd         (e_rd),
    .flush_in     (flush_in),
    .stall_in     (stall_in),
    .hazard       (hazard),
    .stall_f      (stall_f),
    .stall_d      (stall_d)
  );

  // hazard already excludes flush and hold, so a bubble is flush_in || hazard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid    <= 1'b0;
      e_ctrl     <= CTRL_NOP;
      e_rd1      <= '0;
      e_rd2      <= '0;
      e_imm      <= '0;
      e_pc       <= '0;
      e_pc_plus4 <= '0;
      e_rs1      <= '0;
      e_rs2      <= '0;
      e_rd       <= '0;
    end else if (!stall_in) begin
      if (flush_in || hazard) begin
        e_valid    <= 1'b0;
        e_ctrl     <= CTRL_NOP;
        e_rd1      <= '0;
        e_rd2      <= '0;
        e_imm      <= '0;
        e_pc       <= '0;
        e_pc_plus4 <= '0;
        e_rs1      <= '0;
        e_rs2      <= '0;
        e_rd       <= '0;
      end else begin
        e_valid    <= d_valid;
        e_ctrl     <= d_valid ? d_ctrl : CTRL_NOP;
        e_rd1      <= d_rd1;
        e_rd2      <= d_rd2;
        e_imm      <= d_imm;
        e_pc       <= d_pc;
        e_pc_plus4 <= d_pc_plus4;
        e_rs1      <= d_rs1;
        e_rs2      <= d_rs2;
        e_rd       <= d_rd;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!stall_in) begin
      if (flush_in && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (hazard && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary. Sits directly downstream of the decode control unit.
- Registers the decoded control bundle, operands, immediate, PC and register indices into the E stage.
- Detects load-use hazards and inserts a single bubble, stalling F and D for that cycle.
- Honours a branch/jump flush from E and an external hold from later stages.

Parameters:
- DATA_WIDTH, 32, width of operands, immediate and PC.
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- d_valid  in  1  D stage holds a real instruction
- d_reg_write, d_mem_write, d_alu_src, d_branch, d_jump, d_addr_mode  in  1 each  decoded controls
- d_result_src  in  2  encoding: 00 ALU, 01 mem, 10 PC+4, 11 imm
- d_alu_control  in  4  ALU op
- d_funct3  in  3  branch/access type
- d_rd1, d_rd2, d_imm, d_pc, d_pc_plus4  in  DATA_WIDTH  D-stage data
- d_rs1, d_rs2, d_rd  in  REG_ADDR_W  D-stage register indices
- flush_in  in  1  branch/jump taken in E; D instruction is wrong-path
- stall_in  in  1  later stage cannot accept; hold E
- e_valid  out  1  E holds a real instruction
- e_reg_write, e_mem_write, e_alu_src, e_branch, e_jump, e_addr_mode  out  1 each  registered controls
- e_result_src  out  2
- e_alu_control  out  4
- e_funct3  out  3
- e_rd1, e_rd2, e_imm, e_pc, e_pc_plus4  out  DATA_WIDTH
- e_rs1, e_rs2, e_rd  out  REG_ADDR_W
- stall_f, stall_d  out  1  hold PC and IF/ID register (combinational)
- bubble_cnt, flush_cnt  out  CNT_W  performance counters (present only with the optional feature)

Behaviour:
- Reset (asynchronous, active-high):
  - every e_* output is 0. This is a NOP: e_valid=0, e_reg_write=0, e_mem_write=0, e_branch=0, e_jump=0.
  - counters are 0.
  - stall_f/stall_d are 0 while rst is high.
- Hazard is combinational. It is asserted when all of the following hold:
  - d_valid and e_valid
  - e_reg_write=1 and e_result_src=01
  - e_rd != 0
  - e_rd == d_rs1 or e_rd == d_rs2
- Next-state priority at each rising clk:
  1. stall_in=1: all E registers hold. stall_f=stall_d=1. flush_in and hazard are ignored this cycle.
  2. flush_in=1: E loads a bubble (all controls 0, e_valid=0; data fields don't-care, cleared to 0). stall_f=stall_d=0. Hazard is suppressed.
  3. hazard=1: E loads a bubble. stall_f=stall_d=1, so D re-presents the same instruction next cycle.
  4. Otherwise: E loads all d_* fields. e_valid=d_valid. If d_valid=0, all controls are forced to 0.
- Latency: D to E is exactly 1 cycle. A load-use pair costs exactly 1 bubble. Because the bubble has e_result_src=00, the hazard self-clears the next cycle.
- Destination x0 never triggers a hazard, including e_rd=0 with e_result_src=01.
- Back-to-back loads to the same rd each produce independent single bubbles.
- Reset mid-stall: E is cleared immediately and stall_f/stall_d drop with rst.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments on each hazard-bubble insertion; flush_cnt increments on each flush-bubble.
  - Neither counts while stall_in=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: the counter ports and logic are absent. Functional behaviour is identical.

Decomposition:
- Shared package:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4, RES_IMM).
  - ALUControl op constants.
  - packed struct ctrl_t bundling reg_write, mem_write, alu_src, result_src, branch, jump, alu_control, addr_mode, funct3.
  - constant CTRL_NOP = all-zero ctrl_t.
- Sub-module hazard_unit: purely combinational load-use detection, producing hazard, stall_f and stall_d from E/D indices, flush_in and stall_in.

Test Plan:
- Reset released, d_valid=1 with addi x5 (reg_write=1, alu_src=1, imm=7) -> 1 cycle later e_valid=1, e_rd=5, e_imm=7, e_alu_src=1. Before the edge, all e_* are 0.
- lw x6 in E (result_src=01), add x7,x6,x1 in D -> stall_f=stall_d=1 for exactly 1 cycle. E gets a bubble (e_valid=0). Next cycle the add enters E and stall_f/stall_d return to 0.
- lw x0 in E, D uses rs1=0 -> no stall, no bubble.
- flush_in=1 with a load-use hazard present -> E gets a bubble, stall_f=stall_d=0, e_mem_write=0, e_reg_write=0.
- stall_in held 3 cycles with sw in E -> E contents unchanged for 3 cycles and stall_f=1 throughout. A flush_in pulse during the hold has no effect.
- With ID_EX_PERF_CNT_EN: 2 load-use bubbles and 1 flush -> bubble_cnt=2, flush_cnt=1. Asserting rst mid-run clears both counters to 0 asynchronously.
